gpx_event_writer: RTL and testbench
===================================

# gpx_event_writer

Parametrised, multi-channel successor to the single-channel GPX hit writer. Takes timestamped hits (x, y, channel) from the GPX TDC front end, packs each measurement event into a fixed-size slot block of the hit RAM, and pads unused slots after the event closes. Hit RAM is split into two ping-pong banks so downstream readout can drain one event while the next fills. Sits between the GPX decoder and the dual-port hit RAM, in the clk_gpx domain.

## Interface
Parameters:
- X_W, 14, hit x field width
- Y_W, 17, hit y field width
- CH_W, 2, channel id width (2^CH_W channels)
- DEPTH, 16, slots per event (≥2)
- SLOT_W, $clog2(DEPTH), slot index width
- PAD_MODE, 1, 1 = pad remaining slots after done; 0 = stop writing at done

Ports:
- clk_gpx  in  1  GPX clock; one clock, all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_re_start  in  1  global re-arm (synchronous clear)
- in_gpx_start  in  1  event start pulse
- in_gpx_ch  in  CH_W  hit channel
- in_gpx_x  in  X_W  hit x
- in_gpx_y  in  Y_W  hit y
- in_gpx_dv  in  1  hit valid
- in_gpx_done  in  1  event end pulse
- in_bank_release  in  2  one-hot per bank, readout finished
- out_wr_en  out  1  RAM write enable
- out_wr_addr  out  SLOT_W+1  {bank, slot}
- out_wr_x / out_wr_y / out_wr_ch  out  X_W / Y_W / CH_W  write data (0 for pad words)
- out_wr_real  out  1  1 = real hit, 0 = pad word
- out_event_done  out  1  one-cycle pulse, event committed
- out_event_bank  out  1  bank of committed event
- out_event_count  out  SLOT_W+1  real hits in committed event
- out_event_ovf  out  1  event had hits beyond DEPTH (dropped)
- out_drop  out  1  one-cycle pulse, start ignored (no free bank)

## Operation
- States: IDLE, COLLECT, PAD, FINISH.
- IDLE: in_gpx_start with current bank free → COLLECT, slot=0, count=0, ovf=0. Start with current bank full → out_drop pulse, stay IDLE. dv/done ignored.
- COLLECT: dv with slot<DEPTH → write hit at {bank,slot}, slot++, count++. dv with slot==DEPTH → no write, ovf=1. done → PAD if PAD_MODE=1 and slot<DEPTH (after this cycle's hit), else FINISH.
- PAD: one pad write per cycle at {bank,slot}, slot++; after slot DEPTH-1 written → FINISH. dv ignored (ovf=1 if dv arrives).
- FINISH: pulse out_event_done with bank/count/ovf, mark bank full, toggle bank, → IDLE.
- Bank full bits: set in FINISH, cleared by in_bank_release[b]; release and set of same bank in one cycle → set wins.
- in_gpx_start in COLLECT/PAD: abandon event, restart at slot 0 in same bank; no done pulse. start and done same cycle: start wins.
- dv and done same cycle: hit written first, then done processing.
- in_re_start (any state): → IDLE, bank=0, both full bits cleared, count/ovf cleared, no pulses; priority over all other inputs.
- out_event_bank/count/ovf hold until next out_event_done.

## Timing
- All outputs registered. Reset: every output 0; state IDLE, bank 0, banks free.
- Hit dv at cycle t → out_wr_en at t+1 with its data/address.
- done at t: P pad writes at t+2 … t+1+P (P = DEPTH − n, n real hits incl. any at t; P=0 if PAD_MODE=0 or n=DEPTH); out_event_done at t+2+P.
- Next start accepted the cycle after out_event_done.
- rst_n deassertion mid-event: no partial writes after reset; event lost.

## Structure
- Package gpx_pkg: X_W/Y_W/CH_W defaults, state enum, pad word constant, hit record typedef {ch, x, y}.
- Sub-module gpx_bank_ctrl: two full bits, current bank pointer, release/set arbitration, free flag.

## Test plan
- 3 hits (ch 0,1,3) then done, PAD_MODE=1, DEPTH=16 → real writes addr 0–2 at t+1, pads addr 3–15, out_event_done count=3 bank=0 at done+15.
- 18 hits, PAD_MODE=0 → writes addr 0–15 only, ovf=1, count=16, done pulse at done+2.
- Two events, no release → second in bank 1 (addr 16–31); third start → out_drop, no writes; release bank 0 → next start accepted at addr 0.
- dv+done same cycle at n=15, PAD_MODE=1 → hit at addr 15, zero pads, done pulse at done+2, count=16.
- start mid-event after 5 hits → slot restarts at 0 same bank, no done pulse; in_re_start mid-PAD → IDLE, no further writes, banks free.

Source files
------------

// File: rtl/gpx_pkg.sv
// Shared definitions for the GPX event writer: default field widths, FSM states and the pad word.
package gpx_pkg;

  localparam int GPX_X_W  = 14;
  localparam int GPX_Y_W  = 17;
  localparam int GPX_CH_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_PAD     = 2'd2,
    ST_FINISH  = 2'd3
  } gpx_state_t;

  typedef struct packed {
    logic [GPX_CH_W-1:0] ch;
    logic [GPX_X_W-1:0]  x;
    logic [GPX_Y_W-1:0]  y;
  } gpx_hit_t;

  localparam gpx_hit_t GPX_PAD_HIT = '{
    ch: {GPX_CH_W{1'b0}},
    x:  {GPX_X_W{1'b0}},
    y:  {GPX_Y_W{1'b0}}
  };

endpackage

// File: rtl/gpx_bank_ctrl.sv
// Ping-pong bank bookkeeping: per-bank full bits, the bank currently being filled and its free flag.
module gpx_bank_ctrl (
  input  logic       clk_gpx,
  input  logic       rst_n,
  input  logic       srst,
  input  logic       set_full,
  input  logic [1:0] bank_release,
  output logic       bank,
  output logic       bank_free
);

  logic [1:0] full_r;
  logic [1:0] full_nxt_s;
  logic       bank_r;

  // Readout release clears a bank; committing the current bank in the same cycle overrides the release.
  always_comb begin
    full_nxt_s = full_r & ~bank_release;
    if (srst) begin
      full_nxt_s = 2'b00;
    end else if (set_full) begin
      full_nxt_s = (full_r & ~bank_release) | (bank_r ? 2'b10 : 2'b01);
    end else begin
      full_nxt_s = full_r & ~bank_release;
    end
  end

  // Full bits and bank pointer; the pointer flips on every committed event.
  always_ff @(posedge clk_gpx or negedge rst_n) begin
    if (!rst_n) begin
      full_r <= 2'b00;
      bank_r <= 1'b0;
    end else begin
      full_r <= full_nxt_s;
      bank_r <= srst ? 1'b0 : (set_full ? ~bank_r : bank_r);
    end
  end

  assign bank      = bank_r;
  assign bank_free = ~full_r[bank_r];

endmodule

// File: rtl/gpx_event_writer.sv
// Packs GPX hits into fixed-size event slot blocks of a two-bank hit RAM, padding unused slots.
module gpx_event_writer
  import gpx_pkg::*;
#(
  parameter int X_W      = GPX_X_W,
  parameter int Y_W      = GPX_Y_W,
  parameter int CH_W     = GPX_CH_W,
  parameter int DEPTH    = 16,
  parameter int SLOT_W   = $clog2(DEPTH),
  parameter int PAD_MODE = 1
) (
  input  logic              clk_gpx,
  input  logic              rst_n,
  input  logic              in_re_start,
  input  logic              in_gpx_start,
  input  logic [CH_W-1:0]   in_gpx_ch,
  input  logic [X_W-1:0]    in_gpx_x,
  input  logic [Y_W-1:0]    in_gpx_y,
  input  logic              in_gpx_dv,
  input  logic              in_gpx_done,
  input  logic [1:0]        in_bank_release,
  output logic              out_wr_en,
  output logic [SLOT_W:0]   out_wr_addr,
  output logic [X_W-1:0]    out_wr_x,
  output logic [Y_W-1:0]    out_wr_y,
  output logic [CH_W-1:0]   out_wr_ch,
  output logic              out_wr_real,
  output logic              out_event_done,
  output logic              out_event_bank,
  output logic [SLOT_W:0]   out_event_count,
  output logic              out_event_ovf,
  output logic              out_drop
);

  localparam logic [SLOT_W:0] DEPTH_C = (SLOT_W+1)'(DEPTH);
  localparam logic [SLOT_W:0] LAST_C  = (SLOT_W+1)'(DEPTH - 1);
  localparam logic [SLOT_W:0] ONE_C   = {{SLOT_W{1'b0}}, 1'b1};
  localparam logic [SLOT_W:0] ZERO_C  = {(SLOT_W+1){1'b0}};
  localparam bit              PAD_EN  = (PAD_MODE != 0);

  gpx_state_t      state_r, state_nxt_s;
  logic [SLOT_W:0] slot_r, slot_nxt_s, count_r, count_nxt_s, slot_after_s;
  logic            ovf_r, ovf_nxt_s;
  logic            bank_s, bank_free_s, set_full_s, hit_ok_s;
  logic            wr_en_s, wr_real_s, ev_done_s, drop_s;
  logic [X_W-1:0]  wr_x_s;
  logic [Y_W-1:0]  wr_y_s;
  logic [CH_W-1:0] wr_ch_s;

  // A hit is only stored while free slots remain; slot_after_s is the slot index once it lands.
  assign hit_ok_s     = in_gpx_dv && (slot_r < DEPTH_C);
  assign slot_after_s = hit_ok_s ? (slot_r + ONE_C) : slot_r;

  gpx_bank_ctrl u_bank_ctrl (
    .clk_gpx      (clk_gpx),
    .rst_n        (rst_n),
    .srst         (in_re_start),
    .set_full     (set_full_s),
    .bank_release (in_bank_release),
    .bank         (bank_s),
    .bank_free    (bank_free_s)
  );

  // FSM state register.
  always_ff @(posedge clk_gpx or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; re-arm beats everything, a new start abandons the open event.
  always_comb begin
    state_nxt_s = state_r;
    if (in_re_start) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_gpx_start && bank_free_s) state_nxt_s = ST_COLLECT;
          else                             state_nxt_s = ST_IDLE;
        end
        ST_COLLECT: begin
          if (in_gpx_start)     state_nxt_s = ST_COLLECT;
          else if (in_gpx_done) state_nxt_s = (PAD_EN && (slot_after_s < DEPTH_C)) ? ST_PAD : ST_FINISH;
          else                  state_nxt_s = ST_COLLECT;
        end
        ST_PAD: begin
          if (in_gpx_start)           state_nxt_s = ST_COLLECT;
          else if (slot_r == LAST_C)  state_nxt_s = ST_FINISH;
          else                        state_nxt_s = ST_PAD;
        end
        ST_FINISH: state_nxt_s = ST_IDLE;
        default:   state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output and datapath decode: RAM write, commit/drop pulses, slot/count/overflow updates.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_real_s   = 1'b0;
    wr_x_s      = X_W'(GPX_PAD_HIT.x);
    wr_y_s      = Y_W'(GPX_PAD_HIT.y);
    wr_ch_s     = CH_W'(GPX_PAD_HIT.ch);
    ev_done_s   = 1'b0;
    drop_s      = 1'b0;
    set_full_s  = 1'b0;
    slot_nxt_s  = slot_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    if (in_re_start) begin
      slot_nxt_s  = ZERO_C;
      count_nxt_s = ZERO_C;
      ovf_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_gpx_start && bank_free_s) begin
            slot_nxt_s  = ZERO_C;
            count_nxt_s = ZERO_C;
            ovf_nxt_s   = 1'b0;
          end else if (in_gpx_start) begin
            drop_s = 1'b1;
          end else begin
            drop_s = 1'b0;
          end
        end
        ST_COLLECT: begin
          if (in_gpx_start) begin
            slot_nxt_s  = ZERO_C;
            count_nxt_s = ZERO_C;
            ovf_nxt_s   = 1'b0;
          end else if (hit_ok_s) begin
            wr_en_s     = 1'b1;
            wr_real_s   = 1'b1;
            wr_x_s      = in_gpx_x;
            wr_y_s      = in_gpx_y;
            wr_ch_s     = in_gpx_ch;
            slot_nxt_s  = slot_after_s;
            count_nxt_s = count_r + ONE_C;
          end else if (in_gpx_dv) begin
            ovf_nxt_s = 1'b1;
          end else begin
            ovf_nxt_s = ovf_r;
          end
        end
        ST_PAD: begin
          if (in_gpx_start) begin
            slot_nxt_s  = ZERO_C;
            count_nxt_s = ZERO_C;
            ovf_nxt_s   = 1'b0;
          end else begin
            wr_en_s    = 1'b1;
            slot_nxt_s = slot_r + ONE_C;
            ovf_nxt_s  = ovf_r | in_gpx_dv;
          end
        end
        ST_FINISH: begin
          ev_done_s  = 1'b1;
          set_full_s = 1'b1;
        end
        default: begin
          ev_done_s = 1'b0;
        end
      endcase
    end
  end

  // Registered datapath and outputs; event summary holds until the next commit.
  always_ff @(posedge clk_gpx or negedge rst_n) begin
    if (!rst_n) begin
      slot_r          <= ZERO_C;
      count_r         <= ZERO_C;
      ovf_r           <= 1'b0;
      out_wr_en       <= 1'b0;
      out_wr_addr     <= ZERO_C;
      out_wr_x        <= {X_W{1'b0}};
      out_wr_y        <= {Y_W{1'b0}};
      out_wr_ch       <= {CH_W{1'b0}};
      out_wr_real     <= 1'b0;
      out_event_done  <= 1'b0;
      out_event_bank  <= 1'b0;
      out_event_count <= ZERO_C;
      out_event_ovf   <= 1'b0;
      out_drop        <= 1'b0;
    end else begin
      slot_r         <= slot_nxt_s;
      count_r        <= count_nxt_s;
      ovf_r          <= ovf_nxt_s;
      out_wr_en      <= wr_en_s;
      out_wr_addr    <= {bank_s, slot_r[SLOT_W-1:0]};
      out_wr_x       <= wr_x_s;
      out_wr_y       <= wr_y_s;
      out_wr_ch      <= wr_ch_s;
      out_wr_real    <= wr_real_s;
      out_event_done <= ev_done_s;
      out_drop       <= drop_s;
      if (in_re_start) begin
        out_event_bank  <= 1'b0;
        out_event_count <= ZERO_C;
        out_event_ovf   <= 1'b0;
      end else if (ev_done_s) begin
        out_event_bank  <= bank_s;
        out_event_count <= count_r;
        out_event_ovf   <= ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_gpx_event_writer.sv
// Directed bench for gpx_event_writer: a padding and a non-padding instance share one stimulus stream.
module tb_gpx_event_writer;

  logic clk_gpx = 1'b0;
  always #5 clk_gpx = ~clk_gpx;

  logic        rst_n = 1'b0, re_start = 1'b0, gpx_start = 1'b0, gpx_dv = 1'b0, gpx_done = 1'b0;
  logic [1:0]  gpx_ch = 2'd0, bank_release = 2'd0;
  logic [13:0] gpx_x = 14'd0;
  logic [16:0] gpx_y = 17'd0;

  logic        a_wr_en, a_wr_real, a_ev_done, a_ev_bank, a_ev_ovf, a_drop;
  logic [4:0]  a_wr_addr, a_ev_count;
  logic [13:0] a_wr_x;
  logic [16:0] a_wr_y;
  logic [1:0]  a_wr_ch;
  logic        b_wr_en, b_wr_real, b_ev_done, b_ev_bank, b_ev_ovf, b_drop;
  logic [4:0]  b_wr_addr, b_ev_count;
  logic [13:0] b_wr_x;
  logic [16:0] b_wr_y;
  logic [1:0]  b_wr_ch;

  gpx_event_writer #(.PAD_MODE(1)) dut_pad (
    .clk_gpx(clk_gpx), .rst_n(rst_n), .in_re_start(re_start), .in_gpx_start(gpx_start),
    .in_gpx_ch(gpx_ch), .in_gpx_x(gpx_x), .in_gpx_y(gpx_y), .in_gpx_dv(gpx_dv),
    .in_gpx_done(gpx_done), .in_bank_release(bank_release),
    .out_wr_en(a_wr_en), .out_wr_addr(a_wr_addr), .out_wr_x(a_wr_x), .out_wr_y(a_wr_y),
    .out_wr_ch(a_wr_ch), .out_wr_real(a_wr_real), .out_event_done(a_ev_done),
    .out_event_bank(a_ev_bank), .out_event_count(a_ev_count), .out_event_ovf(a_ev_ovf),
    .out_drop(a_drop)
  );

  gpx_event_writer #(.PAD_MODE(0)) dut_nopad (
    .clk_gpx(clk_gpx), .rst_n(rst_n), .in_re_start(re_start), .in_gpx_start(gpx_start),
    .in_gpx_ch(gpx_ch), .in_gpx_x(gpx_x), .in_gpx_y(gpx_y), .in_gpx_dv(gpx_dv),
    .in_gpx_done(gpx_done), .in_bank_release(bank_release),
    .out_wr_en(b_wr_en), .out_wr_addr(b_wr_addr), .out_wr_x(b_wr_x), .out_wr_y(b_wr_y),
    .out_wr_ch(b_wr_ch), .out_wr_real(b_wr_real), .out_event_done(b_ev_done),
    .out_event_bank(b_ev_bank), .out_event_count(b_ev_count), .out_event_ovf(b_ev_ovf),
    .out_drop(b_drop)
  );

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [13:0] x;
    logic [16:0] y;
    logic [1:0]  ch;
    logic        is_real;
  } wr_rec_t;

  typedef struct {
    int         cyc;
    logic       bank;
    logic [4:0] count;
    logic       ovf;
  } ev_rec_t;

  wr_rec_t wa_q[$], wb_q[$];
  ev_rec_t ea_q[$], eb_q[$];
  int      da_q[$];
  int      cyc = 0;
  int      n_assert = 0;
  int      n_fail = 0;
  int      t0, td, tr;
  logic [32:0] s1_exp [3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge and logged.
  task automatic tick();
    @(posedge clk_gpx);
    #1;
    cyc++;
    if (a_wr_en)   wa_q.push_back('{cyc, a_wr_addr, a_wr_x, a_wr_y, a_wr_ch, a_wr_real});
    if (b_wr_en)   wb_q.push_back('{cyc, b_wr_addr, b_wr_x, b_wr_y, b_wr_ch, b_wr_real});
    if (a_ev_done) ea_q.push_back('{cyc, a_ev_bank, a_ev_count, a_ev_ovf});
    if (b_ev_done) eb_q.push_back('{cyc, b_ev_bank, b_ev_count, b_ev_ovf});
    if (a_drop)    da_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    wa_q.delete(); wb_q.delete(); ea_q.delete(); eb_q.delete(); da_q.delete();
  endtask

  task automatic do_start();
    gpx_start = 1'b1; tick(); gpx_start = 1'b0;
  endtask

  task automatic do_done();
    gpx_done = 1'b1; tick(); gpx_done = 1'b0;
  endtask

  task automatic do_re();
    re_start = 1'b1; tick(); re_start = 1'b0;
  endtask

  task automatic do_release(input logic [1:0] m);
    bank_release = m; tick(); bank_release = 2'b00;
  endtask

  task automatic do_hit(input logic [1:0] ch, input logic [13:0] x, input logic [16:0] y);
    gpx_dv = 1'b1; gpx_ch = ch; gpx_x = x; gpx_y = y;
    tick();
    gpx_dv = 1'b0;
  endtask

  function automatic logic [13:0] hx(input int i);
    return 14'(i * 37 + 5);
  endfunction

  function automatic logic [16:0] hy(input int i);
    return 17'(i * 1001 + 3);
  endfunction

  initial begin
    // Reset values
    idle(3);
    chk("rst_wr_en", a_wr_en, 1'b0);
    chk("rst_addr", a_wr_addr, 5'd0);
    chk("rst_ev_done", a_ev_done, 1'b0);
    chk("rst_ev_count", a_ev_count, 5'd0);
    chk("rst_drop", a_drop, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: three hits, padded to 16 slots
    s1_exp[0] = {2'd0, 14'h0123, 17'h00456};
    s1_exp[1] = {2'd1, 14'h3abc, 17'h1def0};
    s1_exp[2] = {2'd3, 14'h2001, 17'h10002};
    clear_q();
    do_start();
    t0 = cyc;
    do_hit(2'd0, 14'h0123, 17'h00456);
    do_hit(2'd1, 14'h3abc, 17'h1def0);
    do_hit(2'd3, 14'h2001, 17'h10002);
    td = cyc;
    do_done();
    idle(20);
    chk("s1_nwr", wa_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      chk("s1_addr", wa_q[i].addr, 5'(i));
      chk("s1_real", wa_q[i].is_real, (i < 3) ? 1'b1 : 1'b0);
      if (i < 3) begin
        chk("s1_cyc_hit", wa_q[i].cyc, t0 + 1 + i);
        chk("s1_data", {wa_q[i].ch, wa_q[i].x, wa_q[i].y}, s1_exp[i]);
      end else begin
        chk("s1_cyc_pad", wa_q[i].cyc, td + 2 + (i - 3));
        chk("s1_pad_data", {wa_q[i].ch, wa_q[i].x, wa_q[i].y}, 33'd0);
      end
    end
    chk("s1_nev", ea_q.size(), 1);
    chk("s1_ev_cyc", ea_q[0].cyc, td + 15);
    chk("s1_ev_count", ea_q[0].count, 5'd3);
    chk("s1_ev_bank", ea_q[0].bank, 1'b0);
    chk("s1_ev_ovf", ea_q[0].ovf, 1'b0);
    chk("s1_count_hold", a_ev_count, 5'd3);

    // 2: 18 hits without padding, overflow
    do_re();
    clear_q();
    do_start();
    for (int i = 0; i < 18; i++) do_hit(2'(i % 4), hx(i), hy(i));
    td = cyc;
    do_done();
    idle(6);
    chk("s2_nwr", wb_q.size(), 16);
    for (int i = 0; i < 16; i++) chk("s2_addr", wb_q[i].addr, 5'(i));
    chk("s2_last_data", {wb_q[15].ch, wb_q[15].x, wb_q[15].y}, {2'd3, hx(15), hy(15)});
    chk("s2_nev", eb_q.size(), 1);
    chk("s2_ev_cyc", eb_q[0].cyc, td + 2);
    chk("s2_ev_count", eb_q[0].count, 5'd16);
    chk("s2_ev_ovf", eb_q[0].ovf, 1'b1);
    chk("s2_pad_nwr", wa_q.size(), 16);
    chk("s2_pad_ev_cyc", ea_q[0].cyc, td + 2);

    // 3: ping-pong banks, drop on full, release
    do_re();
    clear_q();
    do_start(); do_hit(2'd1, 14'd7, 17'd9); do_done(); idle(20);
    do_start(); do_hit(2'd2, 14'd8, 17'd10); do_done(); idle(20);
    chk("s3_nwr", wa_q.size(), 32);
    chk("s3_addr0", wa_q[0].addr, 5'd0);
    chk("s3_addr16", wa_q[16].addr, 5'd16);
    chk("s3_addr31", wa_q[31].addr, 5'd31);
    chk("s3_real31", wa_q[31].is_real, 1'b0);
    chk("s3_nev", ea_q.size(), 2);
    chk("s3_bank0", ea_q[0].bank, 1'b0);
    chk("s3_bank1", ea_q[1].bank, 1'b1);
    tr = cyc;
    do_start();
    do_hit(2'd0, 14'd1, 17'd1);
    idle(3);
    chk("s3_ndrop", da_q.size(), 1);
    chk("s3_drop_cyc", da_q[0], tr + 1);
    chk("s3_nwr_drop", wa_q.size(), 32);
    do_release(2'b01);
    do_start();
    do_hit(2'd3, 14'h1111, 17'h02222);
    idle(2);
    chk("s3_nwr_rel", wa_q.size(), 33);
    chk("s3_addr_rel", wa_q[32].addr, 5'd0);
    chk("s3_ndrop_rel", da_q.size(), 1);

    // 4: dv and done together on the 16th hit
    do_re();
    clear_q();
    do_start();
    for (int i = 0; i < 15; i++) do_hit(2'(i % 4), hx(i), hy(i));
    td = cyc;
    gpx_dv = 1'b1; gpx_done = 1'b1; gpx_ch = 2'd2; gpx_x = hx(15); gpx_y = hy(15);
    tick();
    gpx_dv = 1'b0; gpx_done = 1'b0;
    idle(5);
    chk("s4_nwr", wa_q.size(), 16);
    chk("s4_addr15", wa_q[15].addr, 5'd15);
    chk("s4_cyc15", wa_q[15].cyc, td + 1);
    chk("s4_real15", wa_q[15].is_real, 1'b1);
    chk("s4_nev", ea_q.size(), 1);
    chk("s4_ev_cyc", ea_q[0].cyc, td + 2);
    chk("s4_ev_count", ea_q[0].count, 5'd16);

    // 5: restart mid-event, then re-arm during padding
    do_re();
    clear_q();
    do_start();
    for (int i = 0; i < 5; i++) do_hit(2'd1, hx(i), hy(i));
    do_start();
    do_hit(2'd2, 14'd20, 17'd21);
    do_hit(2'd3, 14'd22, 17'd23);
    td = cyc;
    do_done();
    idle(3);
    tr = cyc;
    do_re();
    idle(5);
    chk("s5_nwr", wa_q.size(), 10);
    chk("s5_restart_addr", wa_q[5].addr, 5'd0);
    chk("s5_restart_addr1", wa_q[6].addr, 5'd1);
    chk("s5_last_pad_addr", wa_q[9].addr, 5'd4);
    chk("s5_last_pad_cyc", wa_q[9].cyc, tr);
    chk("s5_nev", ea_q.size(), 0);
    do_start();
    do_hit(2'd0, 14'd30, 17'd31);
    idle(2);
    chk("s5_nwr_after", wa_q.size(), 11);
    chk("s5_addr_after", wa_q[10].addr, 5'd0);

    // 6: async reset mid-event loses the event
    do_re();
    clear_q();
    do_start();
    do_hit(2'd1, 14'd40, 17'd41);
    do_hit(2'd1, 14'd42, 17'd43);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_wr_en", a_wr_en, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(20);
    chk("s6_nwr", wa_q.size(), 2);
    chk("s6_nev", ea_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
